// File: rtl/csr_pkg.sv
// Shared definitions for the CSR access unit: widths, Zicsr funct3 codes,
// FSM state encoding and small decode helpers.
package csr_pkg;

    localparam int XLEN   = 32;
    localparam int CSR_AW = 12;

    // Zicsr funct3 encodings; 000 and 100 are not CSR instructions.
    typedef enum logic [2:0] {
        CSR_ILL0 = 3'b000,
        CSR_RW   = 3'b001,
        CSR_RS   = 3'b010,
        CSR_RC   = 3'b011,
        CSR_ILL4 = 3'b100,
        CSR_RWI  = 3'b101,
        CSR_RSI  = 3'b110,
        CSR_RCI  = 3'b111
    } csr_funct3_e;

    // Operation kind shared by register and immediate forms (funct3[1:0]).
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } csr_state_e;

    // Immediate forms take their operand from the rs1 field (zimm).
    function automatic logic is_imm(input logic [2:0] f3);
        return f3[2];
    endfunction

    // funct3 000 / 100 carry no CSR operation.
    function automatic logic is_illegal(input logic [2:0] f3);
        return (f3[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/csr_alu.sv
// New-value computation for a CSR read-modify-write: write, set bits or
// clear bits, selected by the operation kind.
module csr_alu #(
    parameter int XLEN = 32
) (
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_old,
    input  logic [XLEN-1:0] i_operand,
    output logic [XLEN-1:0] o_new
);
    import csr_pkg::*;

    // Select the value to be written back to the CSR.
    always_comb begin
        // NOTE: assigning a default first guarantees every path drives o_new,
        // so no latch is inferred for the unused operation code.
        o_new = '0;
        case (i_op)
            OP_RW:   o_new = i_operand;
            OP_RS:   o_new = i_old | i_operand;
            OP_RC:   o_new = i_old & ~i_operand;
            default: o_new = '0;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// Initiator side of the CSR port: runs one Zicsr instruction as a
// read / wait / write sequence against the CSR file and returns the old
// CSR value for rd with a one-cycle done pulse.
module csr_access_unit #(
    parameter int XLEN   = csr_pkg::XLEN,
    parameter int CSR_AW = csr_pkg::CSR_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [CSR_AW-1:0] csr_addr,
    input  logic [4:0]        rs1_idx,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [4:0]        rd_idx,
    input  logic              kill,
    output logic              csr_en,
    output logic              csr_read_en,
    output logic              csr_write_en,
    output logic [CSR_AW-1:0] csr_rsd,
    output logic [XLEN-1:0]   csr_wdata,
    input  logic [XLEN-1:0]   csr_rdata,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic              rd_we,
    output logic [4:0]        rd_idx_q,
    output logic [XLEN-1:0]   rd_data
);
    import csr_pkg::*;

    csr_state_e        r_state;
    csr_state_e        w_next;

    logic [1:0]        r_op;
    logic [CSR_AW-1:0] r_addr;
    logic [4:0]        r_rd_idx;
    logic [XLEN-1:0]   r_operand;
    logic [XLEN-1:0]   r_old;
    logic              r_illegal;
    logic              r_do_write;

    logic              w_accept;
    logic              w_illegal;
    logic              w_is_rw;
    logic              w_skip_read;
    logic              w_skip_write;
    logic [XLEN-1:0]   w_operand;
    logic [XLEN-1:0]   w_new;

    // Decode of the incoming request; only meaningful when it is accepted.
    assign w_accept     = (r_state == ST_IDLE) && start && !kill;
    assign w_illegal    = is_illegal(funct3);
    assign w_is_rw      = (funct3[1:0] == OP_RW);
    assign w_skip_read  = w_is_rw && (rd_idx == 5'd0);
    assign w_skip_write = !w_is_rw && (rs1_idx == 5'd0);
    assign w_operand    = is_imm(funct3) ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_val;

    csr_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .i_op     (r_op),
        .i_old    (r_old),
        .i_operand(r_operand),
        .o_new    (w_new)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_state <= w_next;
        end
    end

    // Next-state logic: sequence chosen at start, kill aborts to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_illegal)        w_next = ST_DONE;
                    else if (w_skip_read) w_next = ST_WRITE;
                    else                  w_next = ST_READ;
                end
            end
            ST_READ:  w_next = ST_WAIT;
            ST_WAIT:  w_next = r_do_write ? ST_WRITE : ST_DONE;
            ST_WRITE: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (kill && (r_state != ST_IDLE)) begin
            w_next = ST_IDLE;
        end
    end

    // Latch request fields at acceptance; capture the old CSR value in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these are plain registers, not a memory array, so all of
            // them are reset to give defined outputs straight out of reset.
            r_op       <= '0;
            r_addr     <= '0;
            r_rd_idx   <= '0;
            r_operand  <= '0;
            r_old      <= '0;
            r_illegal  <= 1'b0;
            r_do_write <= 1'b0;
        end else if (w_accept) begin
            r_op       <= funct3[1:0];
            r_addr     <= csr_addr;
            r_rd_idx   <= rd_idx;
            r_operand  <= w_operand;
            r_old      <= '0;
            r_illegal  <= w_illegal;
            r_do_write <= !w_skip_write;
        end else if (r_state == ST_WAIT) begin
            r_old      <= csr_rdata;
        end
    end

    // Moore outputs decoded from state and latched fields only.
    always_comb begin
        csr_en       = 1'b0;
        csr_read_en  = 1'b0;
        csr_write_en = 1'b0;
        csr_rsd      = '0;
        csr_wdata    = '0;
        done         = 1'b0;
        illegal      = 1'b0;
        rd_we        = 1'b0;
        rd_idx_q     = '0;
        rd_data      = '0;
        case (r_state)
            ST_READ: begin
                csr_en      = 1'b1;
                csr_read_en = 1'b1;
                csr_rsd     = r_addr;
            end
            ST_WRITE: begin
                csr_en       = 1'b1;
                csr_write_en = 1'b1;
                csr_rsd      = r_addr;
                csr_wdata    = w_new;
            end
            ST_DONE: begin
                done     = 1'b1;
                illegal  = r_illegal;
                rd_we    = (r_rd_idx != 5'd0) && !r_illegal;
                rd_idx_q = r_rd_idx;
                rd_data  = r_old;
            end
            default: ;
        endcase
    end

    assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: a behavioural CSR file, directed
// scenarios and randomized instructions checked against a reference model.
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_idx;
    logic [31:0] rs1_val;
    logic [4:0]  rd_idx;
    logic        kill;
    logic        csr_en, csr_read_en, csr_write_en;
    logic [11:0] csr_rsd;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        busy, done, illegal, rd_we;
    logic [4:0]  rd_idx_q;
    logic [31:0] rd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csr_access_unit #(.XLEN(32), .CSR_AW(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .csr_addr(csr_addr), .rs1_idx(rs1_idx), .rs1_val(rs1_val),
        .rd_idx(rd_idx), .kill(kill), .csr_en(csr_en),
        .csr_read_en(csr_read_en), .csr_write_en(csr_write_en),
        .csr_rsd(csr_rsd), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .busy(busy), .done(done), .illegal(illegal), .rd_we(rd_we),
        .rd_idx_q(rd_idx_q), .rd_data(rd_data)
    );

    // Behavioural CSR file: registered read data, write on strobe, preload port.
    logic [31:0] mem [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;

    initial csr_rdata = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (csr_en && csr_read_en) csr_rdata <= mem[csr_rsd];
        if (csr_en && csr_write_en) mem[csr_rsd] <= csr_wdata;
    end

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Reference model: what one instruction should do, from the ISA rules.
    typedef struct {
        bit          rd;
        bit          wr;
        bit          ill;
        bit          we;
        logic [31:0] old;
        logic [31:0] wdata;
        int          lat;
    } exp_t;

    function automatic exp_t model(input logic [2:0] f3, input logic [4:0] r1i,
                                   input logic [31:0] r1v, input logic [4:0] rd,
                                   input logic [31:0] cur);
        exp_t e;
        logic [31:0] op;
        bit rw;
        e = '{default: 0};
        op = f3[2] ? {27'd0, r1i} : r1v;
        rw = (f3 == 3'd1) || (f3 == 3'd5);
        e.ill = (f3 == 3'd0) || (f3 == 3'd4);
        if (e.ill) begin
            e.lat = 1;
        end else begin
            e.rd  = !(rw && rd == 5'd0);
            e.wr  = rw || (r1i != 5'd0);
            e.old = e.rd ? cur : 32'd0;
            if (rw)                            e.wdata = op;
            else if (f3 == 3'd2 || f3 == 3'd6) e.wdata = e.old | op;
            else                               e.wdata = e.old & ~op;
            e.lat = 1 + (e.rd ? 2 : 0) + (e.wr ? 1 : 0);
        end
        e.we = !e.ill && (rd != 5'd0);
        return e;
    endfunction

    // Observations collected over a fixed 8-cycle window after start.
    int          o_reads, o_read_cyc, o_writes, o_write_cyc, o_dones, o_done_cyc;
    int          o_both, o_leak;
    logic [11:0] o_read_addr, o_write_addr;
    logic [31:0] o_wdata, o_rd_data;
    logic        o_rd_we, o_illegal;
    logic [4:0]  o_rd_idx;
    bit          o_busy [1:8];

    task automatic run_op(input logic [2:0] f3, input logic [11:0] a,
                          input logic [4:0] r1i, input logic [31:0] r1v,
                          input logic [4:0] rd, input bit hold_start,
                          input int kill_cyc);
        o_reads = 0; o_writes = 0; o_dones = 0; o_both = 0; o_leak = 0;
        o_read_cyc = -1; o_write_cyc = -1; o_done_cyc = -1;
        o_read_addr = 'x; o_write_addr = 'x; o_wdata = 'x; o_rd_data = 'x;
        o_rd_we = 1'bx; o_illegal = 1'bx; o_rd_idx = 'x;
        @(negedge clk);
        funct3 = f3; csr_addr = a; rs1_idx = r1i; rs1_val = r1v; rd_idx = rd;
        start = 1'b1; kill = (kill_cyc == 0);
        @(posedge clk);
        #1;
        start = hold_start; kill = (kill_cyc == 1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            o_busy[c] = busy;
            if (csr_read_en && csr_write_en) o_both++;
            if (csr_en && csr_read_en) begin
                o_reads++; o_read_cyc = c; o_read_addr = csr_rsd;
            end
            if (csr_en && csr_write_en) begin
                o_writes++; o_write_cyc = c; o_write_addr = csr_rsd; o_wdata = csr_wdata;
            end
            if (done) begin
                o_dones++; o_done_cyc = c; o_rd_data = rd_data;
                o_rd_we = rd_we; o_illegal = illegal; o_rd_idx = rd_idx_q;
            end else if (rd_we || illegal || rd_data != 0 || rd_idx_q != 0) begin
                o_leak++;
            end
            start = hold_start && (c + 1 <= 3);
            if (start) begin
                funct3 = 3'($urandom); csr_addr = 12'($urandom);
                rs1_idx = 5'($urandom); rs1_val = $urandom; rd_idx = 5'($urandom);
            end
            kill = (c + 1 == kill_cyc);
        end
        start = 1'b0; kill = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; funct3 = '0; csr_addr = '0;
        rs1_idx = '0; rs1_val = '0; rd_idx = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, illegal, rd_we, csr_en, csr_read_en, csr_write_en} !== 7'd0) begin
            errors++; $display("FAIL reset_flags got=%b exp=0", {busy, done, illegal, rd_we, csr_en, csr_read_en, csr_write_en});
        end
        checks++;
        if ({csr_rsd, csr_wdata, rd_data, rd_idx_q} !== '0) begin
            errors++; $display("FAIL reset_data rsd=%h wdata=%h rd_data=%h rd_idx_q=%0d exp=0", csr_rsd, csr_wdata, rd_data, rd_idx_q);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_rmw_rs;
        preload(12'h300, 32'h0000_000F);
        run_op(3'b010, 12'h300, 5'd7, 32'h0000_00F0, 5'd5, 1'b0, -1);
        checks++;
        if (o_reads !== 1 || o_read_cyc !== 1 || o_read_addr !== 12'h300) begin
            errors++; $display("FAIL rs_read got n=%0d cyc=%0d addr=%h exp 1/1/300", o_reads, o_read_cyc, o_read_addr);
        end
        checks++;
        if (o_writes !== 1 || o_write_cyc !== 3 || o_wdata !== 32'h0000_00FF) begin
            errors++; $display("FAIL rs_write got n=%0d cyc=%0d data=%h exp 1/3/000000ff", o_writes, o_write_cyc, o_wdata);
        end
        checks++;
        if (o_dones !== 1 || o_done_cyc !== 4 || o_rd_data !== 32'h0F || o_rd_we !== 1'b1 || o_rd_idx !== 5'd5) begin
            errors++; $display("FAIL rs_done got n=%0d cyc=%0d data=%h we=%b rd=%0d exp 1/4/0f/1/5", o_dones, o_done_cyc, o_rd_data, o_rd_we, o_rd_idx);
        end
    endtask

    task automatic test_rci;
        preload(12'h341, 32'hFFFF_FFFF);
        run_op(3'b111, 12'h341, 5'h03, 32'hDEAD_BEEF, 5'd9, 1'b0, -1);
        checks++;
        if (o_wdata !== 32'hFFFF_FFFC || o_write_cyc !== 3) begin
            errors++; $display("FAIL rci_wdata got=%h cyc=%0d exp=fffffffc cyc=3", o_wdata, o_write_cyc);
        end
        checks++;
        if (o_rd_data !== 32'hFFFF_FFFF || o_done_cyc !== 4) begin
            errors++; $display("FAIL rci_rd_data got=%h cyc=%0d exp=ffffffff cyc=4", o_rd_data, o_done_cyc);
        end
    endtask

    task automatic test_write_only;
        run_op(3'b001, 12'h305, 5'd4, 32'h1234_5678, 5'd0, 1'b0, -1);
        checks++;
        if (o_reads !== 0) begin
            errors++; $display("FAIL wo_no_read got=%0d exp=0", o_reads);
        end
        checks++;
        if (o_writes !== 1 || o_write_cyc !== 1 || o_wdata !== 32'h1234_5678) begin
            errors++; $display("FAIL wo_write got n=%0d cyc=%0d data=%h exp 1/1/12345678", o_writes, o_write_cyc, o_wdata);
        end
        checks++;
        if (o_done_cyc !== 2 || o_rd_we !== 1'b0) begin
            errors++; $display("FAIL wo_done got cyc=%0d we=%b exp 2/0", o_done_cyc, o_rd_we);
        end
    endtask

    task automatic test_read_only;
        preload(12'h7C0, 32'h0000_00A5);
        run_op(3'b010, 12'h7C0, 5'd0, 32'hFFFF_FFFF, 5'd3, 1'b0, -1);
        checks++;
        if (o_writes !== 0 || o_reads !== 1) begin
            errors++; $display("FAIL ro_strobes got reads=%0d writes=%0d exp 1/0", o_reads, o_writes);
        end
        checks++;
        if (o_done_cyc !== 3 || o_rd_data !== 32'hA5 || o_rd_we !== 1'b1) begin
            errors++; $display("FAIL ro_done got cyc=%0d data=%h we=%b exp 3/a5/1", o_done_cyc, o_rd_data, o_rd_we);
        end
    endtask

    task automatic test_illegal_and_busy_start;
        run_op(3'b100, 12'h300, 5'd6, 32'h55, 5'd8, 1'b0, -1);
        checks++;
        if (o_done_cyc !== 1 || o_illegal !== 1'b1 || o_rd_we !== 1'b0 || o_reads + o_writes !== 0) begin
            errors++; $display("FAIL illegal got cyc=%0d ill=%b we=%b strobes=%0d exp 1/1/0/0", o_done_cyc, o_illegal, o_rd_we, o_reads + o_writes);
        end
        preload(12'h123, 32'h0F0F_0000);
        run_op(3'b010, 12'h123, 5'd1, 32'h0000_F0F0, 5'd2, 1'b1, -1);
        checks++;
        if (o_dones !== 1 || o_done_cyc !== 4 || o_reads !== 1 || o_writes !== 1) begin
            errors++; $display("FAIL busy_start got dones=%0d cyc=%0d reads=%0d writes=%0d exp 1/4/1/1", o_dones, o_done_cyc, o_reads, o_writes);
        end
        checks++;
        if (o_wdata !== 32'h0F0F_F0F0 || o_write_addr !== 12'h123 || o_busy[5] !== 1'b0) begin
            errors++; $display("FAIL busy_start_data got wdata=%h addr=%h busy5=%b exp 0f0ff0f0/123/0", o_wdata, o_write_addr, o_busy[5]);
        end
    endtask

    task automatic test_kill;
        preload(12'h200, 32'h1111_1111);
        run_op(3'b011, 12'h200, 5'd2, 32'h0000_0001, 5'd4, 1'b0, 2);
        checks++;
        if (o_reads !== 1 || o_writes !== 0 || o_dones !== 0 || o_busy[3] !== 1'b0) begin
            errors++; $display("FAIL kill_wait got reads=%0d writes=%0d dones=%0d busy3=%b exp 1/0/0/0", o_reads, o_writes, o_dones, o_busy[3]);
        end
        run_op(3'b001, 12'h200, 5'd2, 32'h0000_0001, 5'd4, 1'b0, 0);
        checks++;
        if (o_reads + o_writes + o_dones !== 0 || o_busy[1] !== 1'b0) begin
            errors++; $display("FAIL kill_prio got activity=%0d busy1=%b exp 0/0", o_reads + o_writes + o_dones, o_busy[1]);
        end
    endtask

    task automatic test_reset_mid_write;
        bit in_write;
        preload(12'h340, 32'h0000_0011);
        @(negedge clk);
        funct3 = 3'b001; csr_addr = 12'h340; rs1_idx = 5'd1; rs1_val = 32'hCAFE_0000;
        rd_idx = 5'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        in_write = 1'b0;
        for (int c = 1; c <= 6 && !in_write; c++) begin
            @(negedge clk);
            in_write = csr_write_en;
        end
        checks++;
        if (!in_write) begin
            errors++; $display("FAIL rst_mid_reach_write got=0 exp=1");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, rd_we, csr_en, csr_read_en, csr_write_en} !== 6'd0 || csr_wdata !== 32'd0 || csr_rsd !== 12'd0) begin
            errors++; $display("FAIL rst_mid_outputs flags=%b wdata=%h rsd=%h exp 0", {busy, done, rd_we, csr_en, csr_read_en, csr_write_en}, csr_wdata, csr_rsd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (mem[12'h340] !== 32'h0000_0011) begin
            errors++; $display("FAIL rst_mid_no_write got=%h exp=00000011", mem[12'h340]);
        end
    endtask

    task automatic test_random;
        logic [2:0]  f3;
        logic [11:0] a;
        logic [4:0]  r1i, rd;
        logic [31:0] r1v, init;
        exp_t        e;
        for (int n = 0; n < 60; n++) begin
            f3   = 3'($urandom);
            a    = 12'h300 + 12'($urandom_range(0, 7));
            r1i  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            r1v  = $urandom;
            init = $urandom;
            preload(a, init);
            e = model(f3, r1i, r1v, rd, init);
            run_op(f3, a, r1i, r1v, rd, 1'b0, -1);
            checks++;
            if (o_dones !== 1 || o_done_cyc !== e.lat) begin
                errors++; $display("FAIL rnd_done[%0d] f3=%b got n=%0d cyc=%0d exp 1/%0d", n, f3, o_dones, o_done_cyc, e.lat);
            end
            checks++;
            if (o_reads !== int'(e.rd) || (e.rd && (o_read_cyc !== 1 || o_read_addr !== a))) begin
                errors++; $display("FAIL rnd_read[%0d] f3=%b got n=%0d cyc=%0d addr=%h exp n=%0d addr=%h", n, f3, o_reads, o_read_cyc, o_read_addr, e.rd, a);
            end
            checks++;
            if (o_writes !== int'(e.wr) || (e.wr && (o_write_cyc !== e.lat - 1 || o_write_addr !== a || o_wdata !== e.wdata))) begin
                errors++; $display("FAIL rnd_write[%0d] f3=%b got n=%0d cyc=%0d data=%h exp n=%0d data=%h", n, f3, o_writes, o_write_cyc, o_wdata, e.wr, e.wdata);
            end
            checks++;
            if (o_rd_data !== e.old || o_rd_we !== e.we || o_rd_idx !== rd || o_illegal !== e.ill) begin
                errors++; $display("FAIL rnd_rd[%0d] f3=%b got data=%h we=%b idx=%0d ill=%b exp %h/%b/%0d/%b", n, f3, o_rd_data, o_rd_we, o_rd_idx, o_illegal, e.old, e.we, rd, e.ill);
            end
            checks++;
            if (o_both !== 0 || o_leak !== 0) begin
                errors++; $display("FAIL rnd_exclusive[%0d] got both=%0d leak=%0d exp 0/0", n, o_both, o_leak);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rmw_rs();
        test_rci();
        test_write_only();
        test_read_only();
        test_illegal_and_busy_start();
        test_kill();
        test_reset_mid_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
